// File: rtl/spike_time_encoder.sv
// First-spike time encoder: one gamma cycle per start, captures the earliest pulse per line.
// Optional feed-forward inhibition with STE_FFI_EN (limits captures per cycle to FFI_LIMIT).
//
// state   | meaning
// IDLE    | waiting for start
// CAPTURE | time_val counting, first pulses recorded
// HOLD    | spike_times valid, waiting for out_ready
module spike_time_encoder #(
  parameter int NUM_LINES   = 16,
  parameter int TIME_PERIOD = 8,
  parameter int FFI_LIMIT   = 4
) (
  input  logic                                            clk,
  input  logic                                            rst_l,
  input  logic                                            start,
  input  logic [NUM_LINES-1:0]                            spikes_in,
  input  logic                                            out_ready,
  output logic [$clog2(TIME_PERIOD)-1:0]                  time_val,
  output logic [NUM_LINES*($clog2(TIME_PERIOD)+1)-1:0]    spike_times,
  output logic                                            out_valid,
  output logic                                            busy,
  output logic                                            overrun
);

  localparam int TBITS = $clog2(TIME_PERIOD);
  localparam int EW    = TBITS + 1;
  localparam logic [TBITS-1:0] T_LAST   = TBITS'(TIME_PERIOD - 1);
  localparam logic [EW-1:0]    NO_SPIKE = {1'b1, T_LAST};

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_HOLD} state_t;
  state_t state;

  logic [NUM_LINES-1:0] pending;
  logic [NUM_LINES-1:0] admit;

  always_comb begin
    pending = '0;
    for (int i = 0; i < NUM_LINES; i++) pending[i] = spike_times[i*EW + TBITS];
  end

`ifdef STE_FFI_EN
  localparam int CW = $clog2(NUM_LINES + 1);
  logic [CW-1:0] ffi_cnt;
  logic [CW-1:0] ffi_cnt_nxt;

  // lower index lines claim the remaining budget first within a clock
  always_comb begin
    admit       = '0;
    ffi_cnt_nxt = ffi_cnt;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (spikes_in[i] && pending[i] && (int'(ffi_cnt_nxt) < FFI_LIMIT)) begin
        admit[i]    = 1'b1;
        ffi_cnt_nxt = ffi_cnt_nxt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l)
      ffi_cnt <= '0;
    else if ((state == S_IDLE && start) || (state == S_HOLD && out_ready && start))
      ffi_cnt <= '0;
    else if (state == S_CAPTURE)
      ffi_cnt <= ffi_cnt_nxt;
  end
`else
  assign admit = spikes_in & pending;
`endif

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state       <= S_IDLE;
      time_val    <= '0;
      spike_times <= '0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_CAPTURE;
            time_val    <= '0;
            spike_times <= {NUM_LINES{NO_SPIKE}};
            busy        <= 1'b1;
          end
        end
        S_CAPTURE: begin
          if (start) overrun <= 1'b1;
          for (int i = 0; i < NUM_LINES; i++)
            if (admit[i]) spike_times[i*EW +: EW] <= {1'b0, time_val};
          if (time_val == T_LAST) begin
            state     <= S_HOLD;
            time_val  <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            time_val <= time_val + TBITS'(1);
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (start) begin
              state       <= S_CAPTURE;
              time_val    <= '0;
              spike_times <= {NUM_LINES{NO_SPIKE}};
              busy        <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end else if (start) begin
            overrun <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spike_time_encoder.sv
// Self-checking bench for spike_time_encoder (4 lines, period 8, FFI limit 2).
module tb_spike_time_encoder;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        start;
  logic [3:0]  spikes_in;
  logic        out_ready;
  logic [2:0]  time_val;
  logic [15:0] spike_times;
  logic        out_valid;
  logic        busy;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  logic [15:0] sb_q[$];

  spike_time_encoder #(.NUM_LINES(4), .TIME_PERIOD(8), .FFI_LIMIT(2)) dut (
    .clk(clk), .rst_l(rst_l), .start(start), .spikes_in(spikes_in),
    .out_ready(out_ready), .time_val(time_val), .spike_times(spike_times),
    .out_valid(out_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0][3:0] p;
    logic [15:0]     e;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model(input logic [7:0][3:0] p);
    logic [3:0][3:0] e;
    int cnt;
    e = {4{4'hF}};
    cnt = 0;
    for (int t = 0; t < 8; t++)
      for (int i = 0; i < 4; i++)
        if (p[t][i] && e[i][3]) begin
`ifdef STE_FFI_EN
          if (cnt < 2) begin
            e[i] = {1'b0, 3'(t)};
            cnt++;
          end
`else
          e[i] = {1'b0, 3'(t)};
`endif
        end
    return e;
  endfunction

  // scoreboard: pops on every accepted output
  always @(negedge clk) begin
    if (rst_l && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: got %h expected none", spike_times);
      end else begin
        chk("sb_spike_times", 32'(spike_times), 32'(sb_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // start a gamma cycle, play pulses, stop in HOLD
  task automatic run_vec(input logic [7:0][3:0] p, input logic [15:0] e);
    start = 1'b1;
    sb_q.push_back(e);
    step();
    start = 1'b0;
    for (int t = 0; t < 8; t++) begin
      chk("cap_time", 32'(time_val), 32'(t));
      chk("cap_busy", 32'(busy), 32'd1);
      chk("cap_valid", 32'(out_valid), 32'd0);
      spikes_in = p[t];
      step();
    end
    spikes_in = '0;
    chk("hold_valid", 32'(out_valid), 32'd1);
    chk("hold_busy", 32'(busy), 32'd0);
    chk("hold_time", 32'(time_val), 32'd0);
  endtask

  initial begin
    logic [15:0] e_ffi;
    rst_l = 1'b0; start = 1'b0; spikes_in = '0; out_ready = 1'b1;
    step(); step();
    chk("rst_time", 32'(time_val), 32'd0);
    chk("rst_st", 32'(spike_times), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    rst_l = 1'b1;
    step();

    for (int k = 0; k < 8; k++) vt[k].p = '0;
    vt[0].p[2] = 4'b0001; vt[0].p[5] = 4'b1000;                 vt[0].e = 16'h5FF2;
    vt[1].p[1] = 4'b0010; vt[1].p[4] = 4'b0010; vt[1].p[7] = 4'b0100; vt[1].e = 16'hF71F;
    vt[2].p[1] = 4'b1111;
`ifdef STE_FFI_EN
    vt[2].e = 16'hFF11;
`else
    vt[2].e = 16'h1111;
`endif
    vt[3].p[0] = 4'b0001; vt[3].p[3] = 4'b0100; vt[3].p[6] = 4'b1000; vt[3].p[7] = 4'b0010;
`ifdef STE_FFI_EN
    e_ffi = 16'hF3F0;
`else
    e_ffi = 16'h6370;
`endif
    vt[3].e = e_ffi;
    vt[4].e = 16'hFFFF;
    for (int k = 5; k < 8; k++) begin
      for (int t = 0; t < 8; t++) vt[k].p[t] = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      vt[k].e = model(vt[k].p);
    end

    for (int k = 0; k < 8; k++) begin
      run_vec(vt[k].p, vt[k].e);
      step();
      chk("accept_idle_valid", 32'(out_valid), 32'd0);
      chk("accept_idle_busy", 32'(busy), 32'd0);
    end

    // pulses in IDLE are ignored
    spikes_in = 4'hF;
    step();
    spikes_in = '0;
    chk("idle_ignore", 32'(spike_times), 32'(vt[7].e));

    // backpressure: HOLD stable for 5 clocks, start meanwhile flags overrun
    out_ready = 1'b0;
    run_vec(vt[0].p, vt[0].e);
    for (int c = 0; c < 5; c++) begin
      start = (c == 2);
      spikes_in = 4'hF;
      step();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_st", 32'(spike_times), 32'h5FF2);
      chk("bp_busy", 32'(busy), 32'd0);
    end
    start = 1'b0; spikes_in = '0;
    chk("bp_overrun", 32'(overrun), 32'd1);

    // back-to-back: handshake with start re-enters CAPTURE
    out_ready = 1'b1;
    start = 1'b1;
    sb_q.push_back(16'hFFFF);
    step();
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_time", 32'(time_val), 32'd0);
    chk("b2b_valid", 32'(out_valid), 32'd0);
    chk("b2b_st", 32'(spike_times), 32'hFFFF);
    step(); step(); step();
    chk("b2b_t3", 32'(time_val), 32'd3);

    // reset mid-capture abandons it; pulse in that cycle not captured
    rst_l = 1'b0;
    spikes_in = 4'hF;
    void'(sb_q.pop_back());
    step();
    rst_l = 1'b1;
    chk("mrst_time", 32'(time_val), 32'd0);
    chk("mrst_st", 32'(spike_times), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_ovr", 32'(overrun), 32'd0);
    step();
    spikes_in = '0;
    chk("mrst_idle_st", 32'(spike_times), 32'd0);
    chk("mrst_idle_busy", 32'(busy), 32'd0);

    // start during CAPTURE sets overrun and does not restart the count
    start = 1'b1;
    sb_q.push_back(16'hFFFF);
    step();
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ovr_cap", 32'(overrun), 32'd1);
    chk("ovr_time", 32'(time_val), 32'd2);
    begin
      int budget = 20;
      while (!out_valid && budget > 0) begin
        step();
        budget--;
      end
      chk("ovr_done_valid", 32'(out_valid), 32'd1);
    end
    step();
    step();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
